// File: rtl/pipeline_hazard_ctrl.sv
// Hazard scheduler for the 5-stage RV32I pipeline. Keeps a shadow scoreboard
// of EX/MEM/WB, decodes the ID instruction and produces stall, flush,
// forwarding and ID-bypass controls plus saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_inst,
  input  logic             id_valid,
  input  logic             ex_redirect,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             id_bypass_a,
  output logic             id_bypass_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // Forwarding source for one EX operand; MEM wins over WB, loads never forward from MEM.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       mem_v, input logic mem_we, input logic mem_ld, input logic [4:0] mem_rd,
    input logic       wb_v,  input logic wb_we,  input logic [4:0] wb_rd
  );
    logic [1:0] sel;
    if (rs == 5'd0) begin
      sel = FWD_RF;
    end else if (mem_v && mem_we && !mem_ld && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_v && wb_we && (wb_rd == rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // ID decode terms
  logic       use_rs1, use_rs2, wr_rd, is_load;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_we;

  // Shadow scoreboard
  logic       ex_v_q, ex_we_q, ex_ld_q;
  logic [4:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
  logic       mem_v_q, mem_we_q, mem_ld_q;
  logic [4:0] mem_rd_q;
  logic       wb_v_q, wb_we_q;
  logic [4:0] wb_rd_q;
  logic       ex_v_d, ex_we_d, ex_ld_d;
  logic [4:0] ex_rd_d, ex_rs1_d, ex_rs2_d;

  logic             lu;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic unused_inst_bits;
  assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:12]};

  assign id_rs1 = id_inst[19:15];
  assign id_rs2 = id_inst[24:20];
  assign id_rd  = id_inst[11:7];

  // Opcode decode of the ID instruction, gated by id_valid.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_rd   = 1'b0;
    is_load = 1'b0;
    case (id_inst[6:0])
      OP_R:      begin use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1; end
      OP_IALU:   begin use_rs1 = 1'b1; wr_rd = 1'b1; end
      OP_LOAD:   begin use_rs1 = 1'b1; wr_rd = 1'b1; is_load = 1'b1; end
      OP_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_JALR:   begin use_rs1 = 1'b1; wr_rd = 1'b1; end
      OP_JAL:    begin wr_rd = 1'b1; end
      OP_LUI:    begin wr_rd = 1'b1; end
      OP_AUIPC:  begin wr_rd = 1'b1; end
      default:   begin use_rs1 = 1'b0; use_rs2 = 1'b0; wr_rd = 1'b0; is_load = 1'b0; end
    endcase
    use_rs1 = use_rs1 & id_valid;
    use_rs2 = use_rs2 & id_valid;
    is_load = is_load & id_valid;
    id_we   = wr_rd & id_valid & (id_rd != 5'd0);
  end

  // Hazard detection, flush/stall generation, forwarding and bypass; all zero in reset.
  always_comb begin
    lu = ex_v_q && ex_we_q && ex_ld_q &&
         ((use_rs1 && (ex_rd_q == id_rs1)) || (use_rs2 && (ex_rd_q == id_rs2)));
    pc_stall    = reset & lu & ~ex_redirect;
    ifid_stall  = reset & lu & ~ex_redirect;
    ifid_flush  = reset & ex_redirect;
    idex_flush  = reset & (lu | ex_redirect);
    if (reset) begin
      fwd_a = fwd_sel(ex_rs1_q, mem_v_q, mem_we_q, mem_ld_q, mem_rd_q, wb_v_q, wb_we_q, wb_rd_q);
      fwd_b = fwd_sel(ex_rs2_q, mem_v_q, mem_we_q, mem_ld_q, mem_rd_q, wb_v_q, wb_we_q, wb_rd_q);
      id_bypass_a = use_rs1 && (id_rs1 != 5'd0) && wb_v_q && wb_we_q && (wb_rd_q == id_rs1);
      id_bypass_b = use_rs2 && (id_rs2 != 5'd0) && wb_v_q && wb_we_q && (wb_rd_q == id_rs2);
      stall_count = stall_cnt_q;
      flush_count = flush_cnt_q;
    end else begin
      fwd_a       = FWD_RF;
      fwd_b       = FWD_RF;
      id_bypass_a = 1'b0;
      id_bypass_b = 1'b0;
      stall_count = '0;
      flush_count = '0;
    end
  end

  // Next EX entry (ID decode or bubble) and saturating counter increments.
  always_comb begin
    if (idex_flush) begin
      ex_v_d   = 1'b0;
      ex_we_d  = 1'b0;
      ex_ld_d  = 1'b0;
      ex_rd_d  = 5'd0;
      ex_rs1_d = 5'd0;
      ex_rs2_d = 5'd0;
    end else begin
      ex_v_d   = id_valid;
      ex_we_d  = id_we;
      ex_ld_d  = is_load;
      ex_rd_d  = id_rd;
      ex_rs1_d = use_rs1 ? id_rs1 : 5'd0;
      ex_rs2_d = use_rs2 ? id_rs2 : 5'd0;
    end
    if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (ex_redirect && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Scoreboard shift and counter update; reset empties the pipeline view.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_v_q      <= 1'b0;
      ex_we_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      ex_rd_q     <= 5'd0;
      ex_rs1_q    <= 5'd0;
      ex_rs2_q    <= 5'd0;
      mem_v_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_ld_q    <= 1'b0;
      mem_rd_q    <= 5'd0;
      wb_v_q      <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      wb_v_q      <= mem_v_q;
      wb_we_q     <= mem_we_q;
      wb_rd_q     <= mem_rd_q;
      mem_v_q     <= ex_v_q;
      mem_we_q    <= ex_we_q;
      mem_ld_q    <= ex_ld_q;
      mem_rd_q    <= ex_rd_q;
      ex_v_q      <= ex_v_d;
      ex_we_q     <= ex_we_d;
      ex_ld_q     <= ex_ld_d;
      ex_rd_q     <= ex_rd_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus
// randomized instruction streams against a behavioural pipeline model.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        ex_redirect;
  logic        pc_stall, ifid_stall, ifid_flush, idex_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic        id_bypass_a, id_bypass_b;
  logic [3:0]  stall_count, flush_count;

  pipeline_hazard_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .id_inst(id_inst), .id_valid(id_valid),
    .ex_redirect(ex_redirect), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .id_bypass_a(id_bypass_a), .id_bypass_b(id_bypass_b),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic       we;
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rs1;  // 0 when not read
    logic [4:0] rs2;  // 0 when not read
  } ins_t;

  ins_t        m_ex, m_mem, m_wb;
  int          m_stall, m_flush;
  logic [17:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [17:0] act_vec;

  assign act_vec = {pc_stall, ifid_stall, ifid_flush, idex_flush, fwd_a, fwd_b,
                    id_bypass_a, id_bypass_b, stall_count, flush_count};

  function automatic ins_t dec(input logic [31:0] i, input logic v);
    ins_t r;
    logic u1, u2, wr, ld;
    r = '0; u1 = 1'b0; u2 = 1'b0; wr = 1'b0; ld = 1'b0;
    case (i[6:0])
      7'h33: begin u1 = 1'b1; u2 = 1'b1; wr = 1'b1; end
      7'h13: begin u1 = 1'b1; wr = 1'b1; end
      7'h03: begin u1 = 1'b1; wr = 1'b1; ld = 1'b1; end
      7'h23, 7'h63: begin u1 = 1'b1; u2 = 1'b1; end
      7'h67: begin u1 = 1'b1; wr = 1'b1; end
      7'h6F, 7'h37, 7'h17: wr = 1'b1;
      default: ;
    endcase
    if (v) begin
      r.v   = 1'b1;
      r.rd  = i[11:7];
      r.we  = wr && (i[11:7] != 5'd0);
      r.ld  = ld;
      r.rs1 = u1 ? i[19:15] : 5'd0;
      r.rs2 = u2 ? i[24:20] : 5'd0;
    end
    return r;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (m_mem.v && m_mem.we && !m_mem.ld && m_mem.rd == rs) return 2'b10;
    if (m_wb.v && m_wb.we && m_wb.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_byp(input logic [4:0] rs);
    return (rs != 5'd0) && m_wb.v && m_wb.we && (m_wb.rd == rs);
  endfunction

  function automatic logic [31:0] r_op(input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] i_op(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'd0, 5'(rd), 7'h13};
  endfunction
  function automatic logic [31:0] lw_op(input int rd, input int rs1);
    return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'h03};
  endfunction
  function automatic logic [31:0] sw_op(input int rs2, input int rs1);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, 7'h23};
  endfunction

  // One clock of stimulus: drive, push expected response, advance the model.
  task automatic cycle(input logic [31:0] inst, input logic v, input logic redir, input logic rst);
    ins_t d;
    logic lu, stall, iflush;
    logic [17:0] e;
    @(posedge clk);
    #1;
    id_inst = inst; id_valid = v; ex_redirect = redir; reset = rst;
    d  = dec(inst, v);
    lu = m_ex.v && m_ex.we && m_ex.ld &&
         ((d.rs1 != 5'd0 && d.rs1 == m_ex.rd) || (d.rs2 != 5'd0 && d.rs2 == m_ex.rd));
    stall  = lu && !redir;
    iflush = lu || redir;
    if (!rst) e = '0;
    else e = {stall, stall, redir, iflush, m_fwd(m_ex.rs1), m_fwd(m_ex.rs2),
              m_byp(d.rs1), m_byp(d.rs2), 4'(m_stall), 4'(m_flush)};
    exp_q.push_back(e);
    if (!rst) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_stall = 0; m_flush = 0;
    end else begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = iflush ? ins_t'('0) : d;
      if (stall && m_stall < 15) m_stall++;
      if (redir && m_flush < 15) m_flush++;
    end
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    cycle(32'h0000_0013, 1'b0, 1'b0, 1'b0);
    cycle(32'h0000_0013, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  always @(negedge clk) begin
    logic [17:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act_vec !== e) begin
        n_errors++;
        $display("FAIL outputs @%0t: got %h expected %h", $time, act_vec, e);
      end
    end
  end

  localparam logic [6:0] OPS [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                      7'h67, 7'h6F, 7'h37, 7'h17, 7'h7F};

  initial begin
    logic [31:0] ri;
    logic [6:0]  op;
    m_ex = '0; m_mem = '0; m_wb = '0; m_stall = 0; m_flush = 0;
    reset = 1'b0; id_inst = 32'd0; id_valid = 1'b0; ex_redirect = 1'b0;
    do_reset();
    chk("reset_stall_cnt", 32'(stall_count), 32'd0);

    // Load-use: lw x5,0(x1); add x6,x5,x2
    cycle(lw_op(5, 1), 1'b1, 1'b0, 1'b1);
    cycle(r_op(6, 5, 2), 1'b1, 1'b0, 1'b1);
    chk("lu_pc_stall", 32'(pc_stall), 32'd1);
    chk("lu_idex_flush", 32'(idex_flush), 32'd1);
    cycle(r_op(6, 5, 2), 1'b1, 1'b0, 1'b1);
    chk("lu_no_repeat", 32'(pc_stall), 32'd0);
    cycle(32'h0000_0013, 1'b0, 1'b0, 1'b1);
    chk("lu_fwd_a_wb", 32'(fwd_a), 32'd1);
    chk("lu_stall_cnt", 32'(stall_count), 32'd1);

    // ALU forwarding priority
    do_reset();
    cycle(r_op(3, 1, 2), 1'b1, 1'b0, 1'b1);
    cycle(r_op(3, 3, 4), 1'b1, 1'b0, 1'b1);
    cycle(r_op(7, 3, 3), 1'b1, 1'b0, 1'b1);
    chk("alu_fwd_sub", 32'(fwd_a), 32'd2);
    cycle(32'h0000_0013, 1'b0, 1'b0, 1'b1);
    chk("alu_fwd_or_a", 32'(fwd_a), 32'd2);
    chk("alu_fwd_or_b", 32'(fwd_b), 32'd2);
    chk("alu_no_stall", 32'(stall_count), 32'd0);

    // Redirect beats load-use stall
    do_reset();
    cycle(lw_op(5, 1), 1'b1, 1'b0, 1'b1);
    cycle(r_op(6, 5, 2), 1'b1, 1'b1, 1'b1);
    chk("redir_ifid_flush", 32'(ifid_flush), 32'd1);
    chk("redir_idex_flush", 32'(idex_flush), 32'd1);
    chk("redir_no_stall", 32'(pc_stall), 32'd0);
    cycle(32'h0000_0013, 1'b0, 1'b0, 1'b1);
    chk("redir_flush_cnt", 32'(flush_count), 32'd1);
    chk("redir_stall_cnt", 32'(stall_count), 32'd0);

    // x0 destination and unknown opcode
    cycle(i_op(0, 1, 1), 1'b1, 1'b0, 1'b1);
    cycle(r_op(2, 0, 0), 1'b1, 1'b0, 1'b1);
    cycle(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    chk("x0_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("unk_bypass", {30'd0, id_bypass_a, id_bypass_b}, 32'd0);
    chk("unk_stall", 32'(pc_stall), 32'd0);

    // WB bypass
    cycle(r_op(8, 1, 2), 1'b1, 1'b0, 1'b1);
    cycle(i_op(10, 1, 1), 1'b1, 1'b0, 1'b1);
    cycle(i_op(11, 1, 2), 1'b1, 1'b0, 1'b1);
    cycle(sw_op(8, 9), 1'b1, 1'b0, 1'b1);
    chk("byp_b", 32'(id_bypass_b), 32'd1);
    chk("byp_a", 32'(id_bypass_a), 32'd0);

    // Counter saturation and reset with redirect
    for (int k = 0; k < 20; k++) cycle(32'h0000_0013, 1'b1, 1'b1, 1'b1);
    cycle(32'h0000_0013, 1'b1, 1'b0, 1'b1);
    chk("sat_flush_cnt", 32'(flush_count), 32'd15);
    cycle(32'h0000_0013, 1'b1, 1'b1, 1'b0);
    chk("rst_outputs", {14'd0, act_vec}, 32'd0);
    cycle(32'h0000_0013, 1'b1, 1'b0, 1'b1);
    chk("rst_flush_cnt", 32'(flush_count), 32'd0);

    // Randomized streams with a small register set to provoke hazards
    for (int k = 0; k < 800; k++) begin
      op = OPS[$urandom_range(0, 9)];
      ri = {7'($urandom()), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom()), 5'($urandom_range(0, 3)), op};
      if ($urandom_range(0, 19) == 0) ri = 32'hFFFF_FFFF;
      cycle(ri, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 49) != 0));
    end

    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
